// File: rtl/conv2x2_feeder_pkg.sv
// Shared types and constants for the 2x2 convolution window feeder.
package conv2x2_feeder_pkg;
  typedef enum logic [1:0] {ST_LOAD, ST_WGT, ST_EMIT, ST_DONE} state_t;

  localparam int DATA_W_DEF = 8;
  localparam int NUM_WGT    = 4;

  function automatic int win_count(input int img_w);
    return (img_w - 1) * (img_w - 1);
  endfunction
endpackage

// File: rtl/conv2x2_feeder_if.sv
// Pixel/weight stream inputs and convolution-engine outputs of the feeder.
// CONV_FEEDER_OVF_FLAG_EN adds the sticky ovf_err flag.
interface conv2x2_feeder_if
  import conv2x2_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              pix_valid, pix_ready;
  logic [DATA_W-1:0] pix_in;
  logic              wgt_valid, wgt_ready;
  logic [DATA_W-1:0] wgt_in;
  logic              weight_valid;
  logic [DATA_W-1:0] In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4;
  logic              in_valid;
  logic [DATA_W-1:0] In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4;
  logic              done;
`ifdef CONV_FEEDER_OVF_FLAG_EN
  logic              ovf_err;
`endif

  modport slave (
    input  pix_valid, pix_in, wgt_valid, wgt_in,
    output pix_ready, wgt_ready, weight_valid,
           In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4,
           in_valid, In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4, done
`ifdef CONV_FEEDER_OVF_FLAG_EN
    , ovf_err
`endif
  );

  modport master (
    output pix_valid, pix_in, wgt_valid, wgt_in,
    input  pix_ready, wgt_ready, weight_valid,
           In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4,
           in_valid, In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4, done
`ifdef CONV_FEEDER_OVF_FLAG_EN
    , ovf_err
`endif
  );
endinterface

// File: rtl/conv2x2_feeder_buf.sv
// Pixel register file: one write port, combinational 4-tap 2x2 window read.
module conv2x2_feeder_buf #(
  parameter  int IMG_W  = 6,
  parameter  int DATA_W = 8,
  localparam int NPIX   = IMG_W * IMG_W,
  localparam int AW     = $clog2(NPIX),
  localparam int CW     = $clog2(IMG_W)
) (
  input  logic                        clk,
  input  logic                        i_we,
  input  logic [AW-1:0]               i_waddr,
  input  logic [DATA_W-1:0]           i_wdata,
  input  logic [CW-1:0]               i_row,
  input  logic [CW-1:0]               i_col,
  output logic [3:0][DATA_W-1:0]      o_taps
);
  logic [DATA_W-1:0] r_pix [NPIX];
  logic [AW-1:0]     w_base;

  assign w_base = AW'(i_row) * AW'(IMG_W) + AW'(i_col);

  always_ff @(posedge clk)
    if (i_we) r_pix[i_waddr] <= i_wdata;

  // tap 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right
  assign o_taps[0] = r_pix[w_base];
  assign o_taps[1] = r_pix[w_base + AW'(1)];
  assign o_taps[2] = r_pix[w_base + AW'(IMG_W)];
  assign o_taps[3] = r_pix[w_base + AW'(IMG_W + 1)];
endmodule

// File: rtl/conv2x2_feeder.sv
// Buffers an IMG_W x IMG_W frame plus 4 weights, then streams every 2x2 window.
// CONV_FEEDER_OVF_FLAG_EN adds a sticky ovf_err flag for items offered while not ready.
module conv2x2_feeder
  import conv2x2_feeder_pkg::*;
#(
  parameter int IMG_W  = 6,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  conv2x2_feeder_if.slave  bus
);
  localparam int NPIX = IMG_W * IMG_W;
  localparam int NWIN = win_count(IMG_W);
  localparam int AW   = $clog2(NPIX);
  localparam int PCW  = $clog2(NPIX + 1);
  localparam int WCW  = $clog2(NUM_WGT + 1);
  localparam int WAW  = $clog2(NUM_WGT);
  localparam int CW   = $clog2(IMG_W);
  localparam int NWW  = $clog2(NWIN + 1);

  state_t                           r_state;
  logic [PCW-1:0]                   r_pix_cnt;
  logic [WCW-1:0]                   r_wgt_cnt;
  logic [CW-1:0]                    r_row, r_col;
  logic [NWW-1:0]                   r_win_cnt;
  logic                             r_pix_ready, r_wgt_ready, r_weight_valid, r_in_valid, r_done;
  logic [NUM_WGT-1:0][DATA_W-1:0]   r_wout, w_wgt_fwd;
  logic [3:0][DATA_W-1:0]           r_ifm, w_taps;
  logic [DATA_W-1:0]                r_wgt [NUM_WGT];

  logic           w_pix_acc, w_wgt_acc, w_load_done, w_col_last;
  logic [PCW-1:0] w_pix_cnt_n;
  logic [WCW-1:0] w_wgt_cnt_n;
  logic [CW-1:0]  w_row_n, w_col_n;

  assign w_pix_acc   = bus.pix_valid & r_pix_ready;
  assign w_wgt_acc   = bus.wgt_valid & r_wgt_ready;
  assign w_pix_cnt_n = r_pix_cnt + PCW'(w_pix_acc);
  assign w_wgt_cnt_n = r_wgt_cnt + WCW'(w_wgt_acc);
  assign w_load_done = (w_pix_cnt_n == PCW'(NPIX)) && (w_wgt_cnt_n == WCW'(NUM_WGT));

  // Row stops at its last value so the buffer is never addressed past the frame.
  assign w_col_last = (r_col == CW'(IMG_W - 2));
  assign w_col_n    = w_col_last ? '0 : r_col + CW'(1);
  assign w_row_n    = (w_col_last && r_row != CW'(IMG_W - 2)) ? r_row + CW'(1) : r_row;

  // The last weight may land on the same edge the weight outputs load.
  always_comb begin
    for (int k = 0; k < NUM_WGT; k++) begin
      w_wgt_fwd[k] = r_wgt[k];
      if (w_wgt_acc && r_wgt_cnt == WCW'(k)) w_wgt_fwd[k] = bus.wgt_in;
    end
  end

  always_ff @(posedge clk)
    if (w_wgt_acc) r_wgt[r_wgt_cnt[WAW-1:0]] <= bus.wgt_in;

  conv2x2_feeder_buf #(.IMG_W(IMG_W), .DATA_W(DATA_W)) u_buf (
    .clk     (clk),
    .i_we    (w_pix_acc),
    .i_waddr (r_pix_cnt[AW-1:0]),
    .i_wdata (bus.pix_in),
    .i_row   (r_row),
    .i_col   (r_col),
    .o_taps  (w_taps)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_LOAD;
      r_pix_cnt      <= '0;
      r_wgt_cnt      <= '0;
      r_row          <= '0;
      r_col          <= '0;
      r_win_cnt      <= '0;
      r_pix_ready    <= 1'b1;
      r_wgt_ready    <= 1'b1;
      r_weight_valid <= 1'b0;
      r_in_valid     <= 1'b0;
      r_done         <= 1'b0;
      r_wout         <= '0;
      r_ifm          <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_pix_cnt <= w_pix_cnt_n;
          r_wgt_cnt <= w_wgt_cnt_n;
          if (w_load_done) begin
            r_state        <= ST_WGT;
            r_pix_ready    <= 1'b0;
            r_wgt_ready    <= 1'b0;
            r_weight_valid <= 1'b1;
            r_wout         <= w_wgt_fwd;
          end else begin
            r_pix_ready <= (w_pix_cnt_n < PCW'(NPIX));
            r_wgt_ready <= (w_wgt_cnt_n < WCW'(NUM_WGT));
          end
        end
        ST_WGT: begin
          r_state        <= ST_EMIT;
          r_weight_valid <= 1'b0;
          r_in_valid     <= 1'b1;
          r_ifm          <= w_taps;
          r_row          <= w_row_n;
          r_col          <= w_col_n;
          r_win_cnt      <= NWW'(1);
        end
        ST_EMIT: begin
          if (r_win_cnt == NWW'(NWIN)) begin
            r_state    <= ST_DONE;
            r_in_valid <= 1'b0;
            r_ifm      <= '0;
            r_wout     <= '0;
            r_done     <= 1'b1;
          end else begin
            r_ifm     <= w_taps;
            r_row     <= w_row_n;
            r_col     <= w_col_n;
            r_win_cnt <= r_win_cnt + NWW'(1);
          end
        end
        default: begin
          r_state     <= ST_LOAD;
          r_done      <= 1'b0;
          r_pix_cnt   <= '0;
          r_wgt_cnt   <= '0;
          r_row       <= '0;
          r_col       <= '0;
          r_win_cnt   <= '0;
          r_pix_ready <= 1'b1;
          r_wgt_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef CONV_FEEDER_OVF_FLAG_EN
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (rst || r_state == ST_DONE) r_ovf <= 1'b0;
    else if ((bus.pix_valid && !r_pix_ready) || (bus.wgt_valid && !r_wgt_ready)) r_ovf <= 1'b1;
  end
  assign bus.ovf_err = r_ovf;
`endif

  assign bus.pix_ready    = r_pix_ready;
  assign bus.wgt_ready    = r_wgt_ready;
  assign bus.weight_valid = r_weight_valid;
  assign bus.In_Weight_1  = r_wout[0];
  assign bus.In_Weight_2  = r_wout[1];
  assign bus.In_Weight_3  = r_wout[2];
  assign bus.In_Weight_4  = r_wout[3];
  assign bus.in_valid     = r_in_valid;
  assign bus.In_IFM_1     = r_ifm[0];
  assign bus.In_IFM_2     = r_ifm[1];
  assign bus.In_IFM_3     = r_ifm[2];
  assign bus.In_IFM_4     = r_ifm[3];
  assign bus.done         = r_done;
endmodule
